mpu_axi_bram_responder: RTL and testbench

MPU_AXI_BRAM_RESPONDER -- requirements
Module: mpu_axi_bram_responder

---
 rtl/mpu_axi_pkg.sv | 15 +
 rtl/mpu_axi_bram_responder_ram.sv | 34 +++
 rtl/mpu_axi_bram_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mpu_axi_bram_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_axi_pkg.sv
// Shared encodings for the AXI BRAM responder: burst types, response codes
// and the write/read FSM state enums.
package mpu_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

endpackage

// File: rtl/mpu_axi_bram_responder_ram.sv
// Dual-port byte-enable block RAM: one write port, one registered read port.
// Read-first on same-word collisions; read output holds while rd_en is low.
module mpu_axi_bram_responder_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DW/8-1:0] wr_be,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mpu_axi_bram_responder.sv
// AXI4 burst slave in front of a word-addressed BRAM. Independent write and
// read FSMs; valid/ready handshake completes on any edge where both are high.
module mpu_axi_bram_responder
  import mpu_axi_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_AW           = 10
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic                          S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic                          S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic                          S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int AW = C_MEM_AW;
  localparam logic [AW-1:0] ONE = 1;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [1:0] burst,
                                              input logic [7:0] len);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    logic          wrap_ok;
    inc       = a + ONE;
    mask      = '0;
    mask[3:0] = len[3:0];
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == BURST_FIXED)                next_addr = a;
    else if (burst == BURST_WRAP && wrap_ok) next_addr = (a & ~mask) | (inc & mask);
    else                                     next_addr = inc;
  endfunction

  w_state_e w_state, w_state_nx;
  r_state_e r_state, r_state_nx;
  logic     rst_done;

  logic          w_id, w_err;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len, w_cnt;
  logic [1:0]    w_burst, bresp_q;
  logic          r_id;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_len, r_cnt;
  logic [1:0]    r_burst;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_last_beat, r_last_beat;
  logic ram_rd_en;

  // Address bits outside the word index are don't-care (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      rst_done <= 1'b0;
    end else begin
      w_state  <= w_state_nx;
      r_state  <= r_state_nx;
      rst_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx    = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = rst_done;
        if (S_AXI_AWVALID && rst_done) w_state_nx = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && w_last_beat) w_state_nx = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nx    = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = rst_done;
        if (S_AXI_ARVALID && rst_done) r_state_nx = R_ADDR;
      end
      R_ADDR: r_state_nx = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = r_last_beat;
        if (S_AXI_RREADY && r_last_beat) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

  // A WLAST mismatch is sticky; the burst length still comes from AWLEN.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_id    <= 1'b0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else if (aw_hs) begin
      w_id    <= S_AXI_AWID;
      w_addr  <= S_AXI_AWADDR[AW+1:2];
      w_len   <= S_AXI_AWLEN;
      w_burst <= S_AXI_AWBURST;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      if (w_last_beat) begin
        bresp_q <= (w_err || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= next_addr(w_addr, w_burst, w_len);
        w_err  <= w_err | S_AXI_WLAST;
      end
    end
  end

  // r_addr always points one word ahead of the beat currently presented.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else if (ar_hs) begin
      r_id    <= S_AXI_ARID;
      r_addr  <= S_AXI_ARADDR[AW+1:2];
      r_len   <= S_AXI_ARLEN;
      r_burst <= S_AXI_ARBURST;
      r_cnt   <= '0;
    end else if (r_state == R_ADDR) begin
      r_addr <= next_addr(r_addr, r_burst, r_len);
    end else if (r_hs && !r_last_beat) begin
      r_cnt  <= r_cnt + 8'd1;
      r_addr <= next_addr(r_addr, r_burst, r_len);
    end
  end

  assign ram_rd_en   = (r_state == R_ADDR) || (r_hs && !r_last_beat);
  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RID   = r_id;
  assign S_AXI_RRESP = RESP_OKAY;

  mpu_axi_bram_responder_ram #(
    .AW (AW),
    .DW (C_S_AXI_DATA_WIDTH)
  ) u_ram (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (w_hs),
    .wr_be   (S_AXI_WSTRB),
    .wr_addr (w_addr),
    .wr_data (S_AXI_WDATA),
    .rd_en   (ram_rd_en),
    .rd_addr (r_addr),
    .rd_data (S_AXI_RDATA)
  );

endmodule

// File: tb/tb_mpu_axi_bram_responder.sv
// Directed bench for mpu_axi_bram_responder: bursts of each type, byte
// strobes, RREADY back-pressure, WLAST errors and mid-burst reset.
module tb_mpu_axi_bram_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        S_AXI_AWID;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [1:0]  S_AXI_AWBURST;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic        S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic        S_AXI_ARID;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [1:0]  S_AXI_ARBURST;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic        S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wbuf [0:15];

  // clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mpu_axi_bram_responder dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWID    (S_AXI_AWID),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWLEN   (S_AXI_AWLEN),
    .S_AXI_AWBURST (S_AXI_AWBURST),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WLAST   (S_AXI_WLAST),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BID     (S_AXI_BID),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARID    (S_AXI_ARID),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARLEN   (S_AXI_ARLEN),
    .S_AXI_ARBURST (S_AXI_ARBURST),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RID     (S_AXI_RID),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RLAST   (S_AXI_RLAST),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // driver tasks
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic id, input logic [3:0] strb, input bit bad_last,
                           input logic [1:0] exp_resp);
    int n;
    S_AXI_AWADDR  = addr;
    S_AXI_AWLEN   = len[7:0];
    S_AXI_AWBURST = burst;
    S_AXI_AWID    = id;
    S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin tick(); n++; end
    check_eq("aw_wait", 32'(n < 100), 32'd1);
    tick();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      S_AXI_WDATA  = wbuf[i];
      S_AXI_WSTRB  = strb;
      S_AXI_WLAST  = bad_last ? (i == 0) : (i == len);
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 100) begin tick(); n++; end
      check_eq("w_wait", 32'(n < 100), 32'd1);
      tick();
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 100) begin tick(); n++; end
    check_eq("b_wait", 32'(n < 100), 32'd1);
    check_eq("bresp", S_AXI_BRESP, exp_resp);
    check_eq("bid", S_AXI_BID, id);
    tick();
    S_AXI_BREADY = 1'b0;
    check_eq("bvalid_clear", S_AXI_BVALID, 1'b0);
  endtask

  // Returns in the cycle after the AR handshake.
  task automatic read_start(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic id);
    int n;
    S_AXI_ARADDR  = addr;
    S_AXI_ARLEN   = len[7:0];
    S_AXI_ARBURST = burst;
    S_AXI_ARID    = id;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 100) begin tick(); n++; end
    check_eq("ar_wait", 32'(n < 100), 32'd1);
    tick();
    S_AXI_ARVALID = 1'b0;
  endtask

  // scoreboard: pops exp_q per accepted beat, checks hold under back-pressure
  task automatic read_collect(input int len, input bit toggle, input logic id);
    int          beats = 0;
    int          cyc   = 0;
    bit          holding = 0;
    logic [31:0] held_d;
    logic        held_l;
    logic [31:0] exp;
    check_eq("rvalid_addr_phase", S_AXI_RVALID, 1'b0);
    tick();
    check_eq("rvalid_latency", S_AXI_RVALID, 1'b1);
    while (beats <= len && cyc < 200) begin
      S_AXI_RREADY = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (holding) begin
        check_eq("rdata_hold", S_AXI_RDATA, held_d);
        check_eq("rlast_hold", S_AXI_RLAST, held_l);
        holding = 0;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check_eq("rdata", S_AXI_RDATA, exp);
        check_eq("rlast", S_AXI_RLAST, (beats == len));
        check_eq("rid", S_AXI_RID, id);
        check_eq("rresp", S_AXI_RRESP, 2'b00);
        beats++;
      end else if (S_AXI_RVALID) begin
        holding = 1;
        held_d  = S_AXI_RDATA;
        held_l  = S_AXI_RLAST;
      end
      tick();
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    check_eq("read_beats", beats, len + 1);
    if (!toggle) check_eq("read_cycles", cyc, len + 1);
    check_eq("rvalid_after_last", S_AXI_RVALID, 1'b0);
    check_eq("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWBURST = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0; S_AXI_ARBURST = 0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 0;
    repeat (3) tick();
    check_eq("rst_awready", S_AXI_AWREADY, 1'b0);
    check_eq("rst_arready", S_AXI_ARREADY, 1'b0);
    check_eq("rst_wready", S_AXI_WREADY, 1'b0);
    check_eq("rst_bvalid", S_AXI_BVALID, 1'b0);
    check_eq("rst_rvalid", S_AXI_RVALID, 1'b0);
    check_eq("rst_rlast", S_AXI_RLAST, 1'b0);
    check_eq("rst_bid", S_AXI_BID, 1'b0);
    check_eq("rst_rid", S_AXI_RID, 1'b0);
    check_eq("rst_bresp", S_AXI_BRESP, 2'b00);
    check_eq("rst_rresp", S_AXI_RRESP, 2'b00);
    check_eq("rst_rdata", S_AXI_RDATA, 32'h0);
    ARESET = 1'b0;
    tick();
    check_eq("post_rst_awready", S_AXI_AWREADY, 1'b1);
    check_eq("post_rst_arready", S_AXI_ARREADY, 1'b1);

    // INCR write 1..4 at 0x10, INCR read back at full rate
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    axi_write(32'h10, 3, 2'b01, 1'b1, 4'hF, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    read_start(32'h10, 3, 2'b01, 1'b0);
    read_collect(3, 1'b0, 1'b0);

    // WRAP read starting mid-block
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    axi_write(32'h30, 3, 2'b01, 1'b0, 4'hF, 1'b0, 2'b00);
    exp_q.push_back(32'hC); exp_q.push_back(32'hD);
    exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    read_start(32'h38, 3, 2'b10, 1'b1);
    read_collect(3, 1'b0, 1'b1);

    // byte strobes
    wbuf[0] = 32'hFFFF_FFFF;
    axi_write(32'h100, 0, 2'b00, 1'b0, 4'hF, 1'b0, 2'b00);
    wbuf[0] = 32'h0000_0000;
    axi_write(32'h100, 0, 2'b00, 1'b0, 4'b0101, 1'b0, 2'b00);
    exp_q.push_back(32'hFF00_FF00);
    read_start(32'h100, 0, 2'b01, 1'b0);
    read_collect(0, 1'b0, 1'b0);

    // FIXED read repeats the same word
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd1);
    read_start(32'h10, 2, 2'b00, 1'b1);
    read_collect(2, 1'b0, 1'b1);

    // WRAP with non power-of-two len behaves as INCR (0x10.. -> 1,2,3)
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i + 1));
    read_start(32'h10, 2, 2'b10, 1'b0);
    read_collect(2, 1'b0, 1'b0);

    // 8-beat read under 1010 back-pressure
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    axi_write(32'h200, 7, 2'b01, 1'b1, 4'hF, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h1000 + 32'(i));
    read_start(32'h200, 7, 2'b01, 1'b1);
    read_collect(7, 1'b1, 1'b1);

    // INCR wraps modulo memory depth; high address bits alias
    wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hAAAA_0002;
    axi_write(32'hFFC, 1, 2'b01, 1'b0, 4'hF, 1'b0, 2'b00);
    exp_q.push_back(32'hAAAA_0002);
    read_start(32'h0, 0, 2'b01, 1'b0);
    read_collect(0, 1'b0, 1'b0);
    exp_q.push_back(32'd1);
    read_start(32'h1013, 0, 2'b01, 1'b0);
    read_collect(0, 1'b0, 1'b0);

    // early WLAST: both beats still taken, SLVERR
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    axi_write(32'h300, 1, 2'b01, 1'b1, 4'hF, 1'b1, 2'b10);
    exp_q.push_back(32'h55); exp_q.push_back(32'h66);
    read_start(32'h300, 1, 2'b01, 1'b0);
    read_collect(1, 1'b0, 1'b0);

    // reset in the middle of a read burst
    read_start(32'h200, 7, 2'b01, 1'b1);
    tick();
    check_eq("mid_rvalid_before_rst", S_AXI_RVALID, 1'b1);
    ARESET = 1'b1;
    tick();
    check_eq("mid_rst_rvalid", S_AXI_RVALID, 1'b0);
    check_eq("mid_rst_rlast", S_AXI_RLAST, 1'b0);
    check_eq("mid_rst_rdata", S_AXI_RDATA, 32'h0);
    check_eq("mid_rst_rid", S_AXI_RID, 1'b0);
    check_eq("mid_rst_arready", S_AXI_ARREADY, 1'b0);
    ARESET = 1'b0;
    tick();
    check_eq("mid_post_rst_arready", S_AXI_ARREADY, 1'b1);
    check_eq("mid_post_rst_awready", S_AXI_AWREADY, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    read_start(32'h10, 3, 2'b01, 1'b0);
    read_collect(3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
